// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default frame geometry.
// The transmitter side imports the same package so both ends agree on framing.
package uart_pkg;

  // Receiver state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Default oversampling ratio (clken ticks per bit) and data bits per frame.
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// RESET_VAL sets the level both flops take during reset so the synchronised
// output does not show a spurious edge when reset is released.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8N1 (configurable data width), LSB first, oversampled.
// The FSM locks onto the falling start edge, re-checks the line half a bit
// later to reject glitches, then samples every data bit and the stop bit at
// its centre. Good bytes are handed over through a sticky rdy flag; a low
// stop bit produces a one-cycle frame_err pulse instead.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 clken,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int SCNT_W = cnt_width(OVERSAMPLE);
  localparam int BPOS_W = cnt_width(DATA_BITS);

  // Compare points for the oversample counter and bit position.
  localparam logic [SCNT_W-1:0] HALF_M1  = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] FULL_M1  = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BPOS_W-1:0] LAST_BIT = BPOS_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t             state_q,  state_d;
  logic [SCNT_W-1:0]     scnt_q,   scnt_d;
  logic [BPOS_W-1:0]     bitpos_q, bitpos_d;
  logic [DATA_BITS-1:0]  shreg_q,  shreg_d;

  logic [DATA_BITS-1:0]  dout_q;
  logic                  rdy_q;
  logic                  ferr_q;
  logic                  ovr_q;

  // Strobes from the FSM to the status block, valid for one clk.
  logic                  good_byte;
  logic                  bad_stop;

  // rx is asynchronous to clk; the line idles high, so reset the chain high.
  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  // FSM state register: state, oversample counter, bit position, shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      scnt_q   <= '0;
      bitpos_q <= '0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      bitpos_q <= bitpos_d;
      shreg_q  <= shreg_d;
    end
  end

  // Next-state logic; everything advances only on clken ticks.
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bitpos_d  = bitpos_q;
    shreg_d   = shreg_q;
    good_byte = 1'b0;
    bad_stop  = 1'b0;

    if (clken) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            scnt_d  = '0;
          end
        end

        START: begin
          scnt_d = scnt_q + SCNT_W'(1);
          if (scnt_q == HALF_M1) begin
            scnt_d = '0;
            if (!rx_s) begin
              // Still low at mid start bit: genuine frame, now bit-centred.
              state_d  = DATA;
              bitpos_d = '0;
            end else begin
              // Line went back high: glitch, drop it silently.
              state_d = IDLE;
            end
          end
        end

        DATA: begin
          scnt_d = scnt_q + SCNT_W'(1);
          if (scnt_q == FULL_M1) begin
            scnt_d            = '0;
            shreg_d[bitpos_q] = rx_s;
            if (bitpos_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              bitpos_d = bitpos_q + BPOS_W'(1);
            end
          end
        end

        STOP: begin
          scnt_d = scnt_q + SCNT_W'(1);
          if (scnt_q == FULL_M1) begin
            // Leave mid stop bit so a back-to-back start edge is not missed.
            scnt_d = '0;
            state_d = IDLE;
            if (rx_s) begin
              good_byte = 1'b1;
            end else begin
              bad_stop = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          scnt_d  = '0;
        end
      endcase
    end
  end

  // Status flags: byte hand-over, overrun tracking and frame-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      rdy_q  <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= bad_stop;
      if (good_byte) begin
        // A completing byte wins over rdy_clr; the acknowledge still
        // clears any overrun that referred to the previous byte.
        dout_q <= shreg_q;
        rdy_q  <= 1'b1;
        ovr_q  <= rdy_clr ? 1'b0 : (ovr_q | rdy_q);
      end else if (rdy_clr) begin
        rdy_q <= 1'b0;
        ovr_q <= 1'b0;
      end
    end
  end

  assign dout      = dout_q;
  assign rdy       = rdy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: OVERSAMPLE=16, clken every 4th clk,
// rx driven bit by bit on clken tick boundaries.
module tb_uart_receiver;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       clken;
  logic       rdy_clr;
  logic [7:0] dout;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Event counters kept by the monitor below.
  int rdy_rise  = 0;
  int ferr_cnt  = 0;
  int ferr_wide = 0;
  int busy_rise = 0;
  logic rdy_prev  = 1'b0;
  logic ferr_prev = 1'b0;
  logic busy_prev = 1'b0;

  logic [1:0] tick_div = 2'd0;

  uart_receiver #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .clken     (clken),
    .rdy_clr   (rdy_clr),
    .dout      (dout),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clken: one-clk pulse on every 4th rising edge, changed on falling edges.
  initial begin
    clken = 1'b0;
    forever begin
      @(negedge clk);
      tick_div = tick_div + 2'd1;
      clken = (tick_div == 2'd3);
    end
  end

  // Edge/pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (rdy && !rdy_prev)           rdy_rise  <= rdy_rise + 1;
    if (frame_err)                  ferr_cnt  <= ferr_cnt + 1;
    if (frame_err && ferr_prev)     ferr_wide <= ferr_wide + 1;
    if (rx_busy && !busy_prev)      busy_rise <= busy_rise + 1;
    rdy_prev  <= rdy;
    ferr_prev <= frame_err;
    busy_prev <= rx_busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Return 1 ns after the n-th clken rising edge from now.
  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk iff clken);
    #1;
  endtask

  // One bit period on the line.
  task automatic drive_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  // Complete frame: start, 8 data bits LSB first, stop bit of the given level.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    @(posedge clk);
    #1;
    rdy_clr = 1'b0;
  endtask

  int b_busy;
  int b_ferr;
  int b_rdy;

  initial begin
    rst     = 1'b1;
    rx      = 1'b1;
    rdy_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("reset_ovr", 32'(overrun), 32'd0);
    check("reset_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    wait_ticks(4);

    // 1: single good frame 0x55.
    send_frame(8'h55, 1'b1);
    wait_ticks(4);
    check("t1_rdy", 32'(rdy), 32'd1);
    check("t1_dout", 32'(dout), 32'h55);
    check("t1_ovr", 32'(overrun), 32'd0);
    check("t1_ferr_cnt", 32'(ferr_cnt), 32'd0);
    check("t1_rdy_rises", 32'(rdy_rise), 32'd1);
    pulse_clr();
    #2;
    check("t1_rdy_cleared", 32'(rdy), 32'd0);
    wait_ticks(2);

    // 2: 5-tick low glitch is rejected.
    b_busy = busy_rise;
    b_ferr = ferr_cnt;
    rx = 1'b0;
    wait_ticks(3);
    check("t2_busy_mid", 32'(rx_busy), 32'd1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(6);
    check("t2_busy_end", 32'(rx_busy), 32'd0);
    check("t2_rdy", 32'(rdy), 32'd0);
    check("t2_busy_pulses", 32'(busy_rise - b_busy), 32'd1);
    check("t2_ferr", 32'(ferr_cnt - b_ferr), 32'd0);
    wait_ticks(2);

    // 3: frame 0xA3 with stop bit low.
    b_ferr = ferr_cnt;
    b_rdy  = rdy_rise;
    send_frame(8'hA3, 1'b0);
    wait_ticks(6);
    check("t3_ferr_pulses", 32'(ferr_cnt - b_ferr), 32'd1);
    check("t3_ferr_width", 32'(ferr_wide), 32'd0);
    check("t3_rdy", 32'(rdy), 32'd0);
    check("t3_dout_held", 32'(dout), 32'h55);
    check("t3_busy", 32'(rx_busy), 32'd0);
    check("t3_no_rdy_rise", 32'(rdy_rise - b_rdy), 32'd0);

    // 4: back-to-back 0x01, 0xFE without acknowledge -> overrun.
    send_frame(8'h01, 1'b1);
    send_frame(8'hFE, 1'b1);
    wait_ticks(2);
    check("t4_dout", 32'(dout), 32'hFE);
    check("t4_rdy", 32'(rdy), 32'd1);
    check("t4_ovr", 32'(overrun), 32'd1);
    pulse_clr();
    #2;
    check("t4_rdy_clr", 32'(rdy), 32'd0);
    check("t4_ovr_clr", 32'(overrun), 32'd0);
    wait_ticks(2);

    // 5: rdy pending from 0x11, then rdy_clr lands on the 0x3C completion edge.
    send_frame(8'h11, 1'b1);
    wait_ticks(2);
    check("t5_pre_rdy", 32'(rdy), 32'd1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(8'h3C >> i);
    rx = 1'b1;
    // Completion is the 9th tick into the stop bit (1-tick detection lag).
    wait_ticks(8);
    repeat (3) @(posedge clk);
    #1;
    rdy_clr = 1'b1;
    @(posedge clk);
    #1;
    rdy_clr = 1'b0;
    wait_ticks(9);
    check("t5_rdy", 32'(rdy), 32'd1);
    check("t5_dout", 32'(dout), 32'h3C);
    check("t5_ovr", 32'(overrun), 32'd0);

    // 6: reset during data bit 4 of 0xF0, then receive 0x0F.
    b_ferr = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b1;
    wait_ticks(8);
    rst = 1'b1;
    #2;
    check("t6_rst_dout", 32'(dout), 32'h00);
    check("t6_rst_rdy", 32'(rdy), 32'd0);
    check("t6_rst_ovr", 32'(overrun), 32'd0);
    check("t6_rst_ferr", 32'(frame_err), 32'd0);
    check("t6_rst_busy", 32'(rx_busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ticks(20);
    send_frame(8'h0F, 1'b1);
    wait_ticks(2);
    check("t6_dout", 32'(dout), 32'h0F);
    check("t6_rdy", 32'(rdy), 32'd1);
    check("t6_ovr", 32'(overrun), 32'd0);
    check("t6_ferr", 32'(ferr_cnt - b_ferr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
